acsu: RTL

Add-compare-select unit for the 4-state, rate-1/2, K=3 (generators 7/5 octal) hard-decision Viterbi decoder. Sits directly upstream of the path-metric register stage. It consumes the current path metrics fed back from that stage plus one received 2-bit symbol, and produces the four new path metrics, the per-state survivor decision bits and the best-state index. Results are registered. A two-state handshake FSM ensures every accepted symbol sees path metrics already updated by the previous one.

---
 rtl/acsu_if.sv | 34 +++
 rtl/acsu.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/acsu_if.sv
// Bundle between the ACSU, the symbol source and the path-metric register stage.
// The slave modport is the ACSU side; the master modport is the source/downstream side.
interface acsu_if;
    logic       valid_i;
    logic       ready_o;
    logic [1:0] sym_i;
    logic [7:0] pm_current_s0_i;
    logic [7:0] pm_current_s1_i;
    logic [7:0] pm_current_s2_i;
    logic [7:0] pm_current_s3_i;
    logic [7:0] pm_new_s0_o;
    logic [7:0] pm_new_s1_o;
    logic [7:0] pm_new_s2_o;
    logic [7:0] pm_new_s3_o;
    logic       valid_o;
    logic [3:0] dec_o;
    logic [1:0] best_state_o;
    logic       norm_o;
    logic [15:0] sym_cnt_o;

    modport slave (
        input  valid_i, sym_i,
        input  pm_current_s0_i, pm_current_s1_i, pm_current_s2_i, pm_current_s3_i,
        output ready_o, valid_o, dec_o, best_state_o, norm_o, sym_cnt_o,
        output pm_new_s0_o, pm_new_s1_o, pm_new_s2_o, pm_new_s3_o
    );

    modport master (
        output valid_i, sym_i,
        output pm_current_s0_i, pm_current_s1_i, pm_current_s2_i, pm_current_s3_i,
        input  ready_o, valid_o, dec_o, best_state_o, norm_o, sym_cnt_o,
        input  pm_new_s0_o, pm_new_s1_o, pm_new_s2_o, pm_new_s3_o
    );
endinterface

// File: rtl/acsu.sv
// Add-compare-select unit for the 4-state K=3 (7,5) hard-decision Viterbi decoder.
// Optional feature: define ACSU_NORM_EN to subtract the minimum selected metric before
// registering and flag it on norm_o; otherwise metrics saturate at 255 and norm_o is 0.
module acsu (
    input logic clk,
    input logic rst,
    acsu_if.slave bus
);

    typedef enum logic {StIdle, StOut} state_e;

    state_e state_q, state_d;
    logic   accept;

    logic [7:0]  pm_cur [4];
    logic [7:0]  sel [4];
    logic [7:0]  pm_next [4];
    logic [3:0]  dec_d;
    logic [7:0]  min_v;
    logic [1:0]  best_d;
    logic        norm_d;

    logic [7:0]  pm_new_q [4];
    logic [3:0]  dec_q;
    logic [1:0]  best_q;
    logic        norm_q;
    logic [15:0] sym_cnt_q;

    // Expected encoder output for the branch into ns from its even (odd=0) or odd predecessor.
    function automatic logic [1:0] exp_sym(input logic [1:0] ns, input logic odd);
        logic [1:0] e;
        case ({ns, odd})
            3'b000:  e = 2'b00;
            3'b001:  e = 2'b11;
            3'b010:  e = 2'b10;
            3'b011:  e = 2'b01;
            3'b100:  e = 2'b11;
            3'b101:  e = 2'b00;
            3'b110:  e = 2'b01;
            default: e = 2'b10;
        endcase
        return e;
    endfunction

    function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

    assign pm_cur[0] = bus.pm_current_s0_i;
    assign pm_cur[1] = bus.pm_current_s1_i;
    assign pm_cur[2] = bus.pm_current_s2_i;
    assign pm_cur[3] = bus.pm_current_s3_i;

    assign accept = (state_q == StIdle) && bus.valid_i;

    // Handshake FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake FSM: next state; OUT always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign bus.ready_o = (state_q == StIdle);
    assign bus.valid_o = (state_q == StOut);

    // Add-compare-select per next state; a tie keeps the even predecessor.
    always_comb begin
        logic [1:0] ns_v;
        logic [1:0] p0;
        logic [1:0] p1;
        logic [8:0] c0;
        logic [8:0] c1;
        logic [7:0] s0;
        logic [7:0] s1;
        dec_d = '0;
        ns_v  = '0;
        p0    = '0;
        p1    = '0;
        c0    = '0;
        c1    = '0;
        s0    = '0;
        s1    = '0;
        for (int i = 0; i < 4; i++) begin
            ns_v = 2'(i);
            p0   = {ns_v[0], 1'b0};
            p1   = {ns_v[0], 1'b1};
            c0   = {1'b0, pm_cur[p0]} + {7'b0, hamming(bus.sym_i, exp_sym(ns_v, 1'b0))};
            c1   = {1'b0, pm_cur[p1]} + {7'b0, hamming(bus.sym_i, exp_sym(ns_v, 1'b1))};
            s0   = c0[8] ? 8'hff : c0[7:0];
            s1   = c1[8] ? 8'hff : c1[7:0];
            if (s1 < s0) begin
                sel[ns_v]   = s1;
                dec_d[ns_v] = 1'b1;
            end else begin
                sel[ns_v]   = s0;
                dec_d[ns_v] = 1'b0;
            end
        end
    end

    // Minimum search (lowest index wins ties) and optional normalization.
    always_comb begin
        logic [1:0] idx;
        idx    = '0;
        min_v  = sel[0];
        best_d = 2'd0;
        for (int i = 1; i < 4; i++) begin
            idx = 2'(i);
            if (sel[idx] < min_v) begin
                min_v  = sel[idx];
                best_d = idx;
            end
        end
        for (int i = 0; i < 4; i++) begin
            idx = 2'(i);
`ifdef ACSU_NORM_EN
            pm_next[idx] = sel[idx] - min_v;
`else
            pm_next[idx] = sel[idx];
`endif
        end
`ifdef ACSU_NORM_EN
        norm_d = (min_v != 8'd0);
`else
        norm_d = 1'b0;
`endif
    end

    // Result registers load only on an accepted symbol and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) pm_new_q[i] <= '0;
            dec_q     <= '0;
            best_q    <= '0;
            norm_q    <= 1'b0;
            sym_cnt_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < 4; i++) pm_new_q[i] <= pm_next[i];
            dec_q     <= dec_d;
            best_q    <= best_d;
            norm_q    <= norm_d;
            sym_cnt_q <= sym_cnt_q + 16'd1;
        end
    end

    assign bus.pm_new_s0_o  = pm_new_q[0];
    assign bus.pm_new_s1_o  = pm_new_q[1];
    assign bus.pm_new_s2_o  = pm_new_q[2];
    assign bus.pm_new_s3_o  = pm_new_q[3];
    assign bus.dec_o        = dec_q;
    assign bus.best_state_o = best_q;
    assign bus.norm_o       = norm_q;
    assign bus.sym_cnt_o    = sym_cnt_q;

endmodule
